pcie_rq_seq_tracker: RTL and testbench
======================================

// Module: pcie_rq_seq_tracker
// PURPOSE
// Tracks in-flight PCIe RQ TLPs using core-returned transmit sequence numbers, generalised to SEQ_PORTS return ports.
// Issues a sequence number per granted TLP, enforces an in-flight limit, checks return order, and keeps statistics.
// Sits between the DMA write/read TX engines and the PCIe hard-IP RQ sequence-number outputs in dma_bench designs.
// PARAMETERS
// SEQ_NUM_WIDTH  6   width of one sequence number; tags wrap modulo 2**SEQ_NUM_WIDTH
// SEQ_PORTS      2   number of sequence-number return ports (1..4)
// TX_LIMIT       16  max in-flight TLPs; 1 <= TX_LIMIT <= 2**(SEQ_NUM_WIDTH-1)
// STAT_WIDTH     32  width of statistics counters
// PORTS
// clk                        in   1                        clock, all logic rising-edge
// rst_n                      in   1                        asynchronous, active-low reset
// enable                     in   1                        1 = grants allowed
// stat_clear                 in   1                        pulse: zero stats and sticky errors
// tx_req                     in   1                        engine requests to send one TLP
// tx_grant                   out  1                        TLP may be sent this cycle
// tx_seq_num                 out  SEQ_NUM_WIDTH            tag for the granted TLP
// s_axis_rq_seq_num          in   SEQ_PORTS*SEQ_NUM_WIDTH  returned tags, port i at [i*W +: W]
// s_axis_rq_seq_num_valid    in   SEQ_PORTS                per-port return valid
// inflight_count             out  SEQ_NUM_WIDTH            TLPs issued, not yet returned
// stat_issued                out  STAT_WIDTH               total grants
// stat_returned              out  STAT_WIDTH               total accepted returns
// stat_max_inflight          out  SEQ_NUM_WIDTH            high-water mark of inflight_count
// err_order                  out  1                        sticky: returned tag != expected tag
// err_underflow              out  1                        sticky: return while nothing in flight
// BEHAVIOUR
// - Reset: head=tail=0, inflight_count=0, all stats 0, errs 0; tx_grant=0 while rst_n low; tx_seq_num=0.
// - tx_grant = tx_req & enable & (inflight_count < TX_LIMIT); combinational from registered count, no return bypass.
// - tx_seq_num = head (registered); on grant head <= head+1 mod 2**SEQ_NUM_WIDTH, stat_issued++.
// - Returns: ports processed in ascending index among valid bits; k-th valid port compared to tail+k.
// - Mismatch sets err_order; tail still advances by count of accepted returns (resync by count, not value).
// - Underflow: returns exceeding (inflight_count + grant) in one cycle are dropped, set err_underflow, not counted.
// - inflight_count next = inflight_count + grant - accepted_returns (same-cycle grant and return net out).
// - A return same cycle as grant may retire that granted tag (tail==head case counts as valid, not underflow).
// - stat_max_inflight <= max(stat_max_inflight, next inflight_count) each cycle.
// - Stat counters saturate at all-ones; no wrap.
// - stat_clear: zeros stat_* and err_*; head, tail, inflight_count unchanged; same-cycle increments are lost (clear wins).
// - enable=0 blocks new grants only; returns continue to retire.
// - Async reset mid-operation discards all tracking; hard IP must be reset together.
// - Single state machine: none beyond pointers; latency grant->count update 1 cycle, return->count update 1 cycle.
// TESTING
// - Reset then tx_req=1 for 20 cycles, no returns, TX_LIMIT=16 -> 16 grants, tags 0..15, inflight=16, grant then 0.
// - At inflight=16, return tags 0,1 on ports 0,1 same cycle -> inflight=14 next cycle, grant resumes, next tag 16.
// - Issue 70 TLPs with steady in-order returns -> tx_seq_num wraps 63->0, no err_order, stat_issued=70.
// - Return tag 5 when tail=3 -> err_order=1 sticky, tail=4; stat_clear -> err_order=0, inflight unchanged.
// - inflight=1, both ports valid -> one accepted, err_underflow=1, stat_returned +1, inflight=0.
// - Assert rst_n low mid-burst with inflight=9 -> all outputs 0 immediately, next tag after release is 0.

Source files
------------

// File: rtl/pcie_rq_seq_tracker.sv
// In-flight tracker for PCIe RQ TLPs: hands out transmit sequence numbers, retires
// them from the core's multi-port return stream, checks return order and keeps statistics.
module pcie_rq_seq_tracker #(
    parameter int SEQ_NUM_WIDTH = 6,
    parameter int SEQ_PORTS     = 2,
    parameter int TX_LIMIT      = 16,
    parameter int STAT_WIDTH    = 32
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               enable,
    input  logic                               stat_clear,
    input  logic                               tx_req,
    output logic                               tx_grant,
    output logic [SEQ_NUM_WIDTH-1:0]           tx_seq_num,
    input  logic [SEQ_PORTS*SEQ_NUM_WIDTH-1:0] s_axis_rq_seq_num,
    input  logic [SEQ_PORTS-1:0]               s_axis_rq_seq_num_valid,
    output logic [SEQ_NUM_WIDTH-1:0]           inflight_count,
    output logic [STAT_WIDTH-1:0]              stat_issued,
    output logic [STAT_WIDTH-1:0]              stat_returned,
    output logic [SEQ_NUM_WIDTH-1:0]           stat_max_inflight,
    output logic                               err_order,
    output logic                               err_underflow
);

    localparam int W = SEQ_NUM_WIDTH;
    localparam logic [W-1:0] LIMIT = W'(TX_LIMIT);
    localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

    logic [W-1:0]          head_q, head_d;
    logic [W-1:0]          tail_q, tail_d;
    logic [W-1:0]          inflight_q, inflight_d;
    logic [STAT_WIDTH-1:0] issued_q, issued_d;
    logic [STAT_WIDTH-1:0] returned_q, returned_d;
    logic [W-1:0]          max_q, max_d;
    logic                  err_order_q, err_order_d;
    logic                  err_underflow_q, err_underflow_d;

    logic                  grant;
    logic [W:0]            avail;
    logic [W:0]            acc_cnt;
    logic                  order_mis;
    logic                  under;
    logic [STAT_WIDTH:0]   ret_sum;

    // Grant sees only the registered count; a same-cycle return never frees a slot early.
    assign grant = rst_n & tx_req & enable & (inflight_q < LIMIT);

    always_comb begin
        // A tag granted this cycle is already retirable, so it counts toward what may return.
        avail     = {1'b0, inflight_q} + {{W{1'b0}}, grant};
        acc_cnt   = '0;
        order_mis = 1'b0;
        under     = 1'b0;
        for (int i = 0; i < SEQ_PORTS; i++) begin
            if (s_axis_rq_seq_num_valid[i]) begin
                if (acc_cnt < avail) begin
                    if (s_axis_rq_seq_num[i*W +: W] != tail_q + acc_cnt[W-1:0]) begin
                        order_mis = 1'b1;
                    end
                    acc_cnt = acc_cnt + (W+1)'(1);
                end else begin
                    under = 1'b1;
                end
            end
        end

        head_d     = grant ? head_q + W'(1) : head_q;
        // Tail follows the count of accepted returns, not their values, so one bad tag
        // does not desynchronise the following ones.
        tail_d     = tail_q + acc_cnt[W-1:0];
        inflight_d = W'(avail - acc_cnt);

        ret_sum    = {1'b0, returned_q} + (STAT_WIDTH+1)'(acc_cnt);

        if (stat_clear) begin
            issued_d        = '0;
            returned_d      = '0;
            max_d           = '0;
            err_order_d     = 1'b0;
            err_underflow_d = 1'b0;
        end else begin
            issued_d        = (grant && issued_q != STAT_MAX) ? issued_q + STAT_WIDTH'(1) : issued_q;
            returned_d      = ret_sum[STAT_WIDTH] ? STAT_MAX : ret_sum[STAT_WIDTH-1:0];
            max_d           = (inflight_d > max_q) ? inflight_d : max_q;
            err_order_d     = err_order_q | order_mis;
            err_underflow_d = err_underflow_q | under;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q          <= '0;
            tail_q          <= '0;
            inflight_q      <= '0;
            issued_q        <= '0;
            returned_q      <= '0;
            max_q           <= '0;
            err_order_q     <= 1'b0;
            err_underflow_q <= 1'b0;
        end else begin
            head_q          <= head_d;
            tail_q          <= tail_d;
            inflight_q      <= inflight_d;
            issued_q        <= issued_d;
            returned_q      <= returned_d;
            max_q           <= max_d;
            err_order_q     <= err_order_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    assign tx_grant          = grant;
    assign tx_seq_num        = head_q;
    assign inflight_count    = inflight_q;
    assign stat_issued       = issued_q;
    assign stat_returned     = returned_q;
    assign stat_max_inflight = max_q;
    assign err_order         = err_order_q;
    assign err_underflow     = err_underflow_q;

endmodule

// File: tb/tb_pcie_rq_seq_tracker.sv
// Bench for pcie_rq_seq_tracker: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_pcie_rq_seq_tracker;

    localparam int W     = 6;
    localparam int PORTS = 2;
    localparam int LIMIT = 16;
    localparam int SW    = 8;
    localparam int SMAX  = 255;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic              stat_clear = 1'b0;
    logic              tx_req = 1'b0;
    logic              tx_grant;
    logic [W-1:0]      tx_seq_num;
    logic [PORTS*W-1:0] seqv = '0;
    logic [PORTS-1:0]  vld = '0;
    logic [W-1:0]      inflight_count;
    logic [SW-1:0]     stat_issued;
    logic [SW-1:0]     stat_returned;
    logic [W-1:0]      stat_max_inflight;
    logic              err_order;
    logic              err_underflow;

    int total = 0;
    int bad   = 0;

    pcie_rq_seq_tracker #(
        .SEQ_NUM_WIDTH(W), .SEQ_PORTS(PORTS), .TX_LIMIT(LIMIT), .STAT_WIDTH(SW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .stat_clear(stat_clear),
        .tx_req(tx_req), .tx_grant(tx_grant), .tx_seq_num(tx_seq_num),
        .s_axis_rq_seq_num(seqv), .s_axis_rq_seq_num_valid(vld),
        .inflight_count(inflight_count), .stat_issued(stat_issued),
        .stat_returned(stat_returned), .stat_max_inflight(stat_max_inflight),
        .err_order(err_order), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outstanding tags held in a FIFO in issue order.
    int m_q[$];
    int m_head = 0;
    int m_iss = 0;
    int m_ret = 0;
    int m_max = 0;
    bit m_eo = 0;
    bit m_eu = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_head = 0; m_iss = 0; m_ret = 0; m_max = 0; m_eo = 0; m_eu = 0;
        end else begin
            int acc;
            int t;
            bit g;
            acc = 0;
            g = tx_req && enable && (m_q.size() < LIMIT);
            if (g) begin
                m_q.push_back(m_head);
                m_head = (m_head + 1) % 64;
                if (m_iss < SMAX) m_iss++;
            end
            for (int p = 0; p < PORTS; p++) begin
                if (vld[p]) begin
                    if (m_q.size() > 0) begin
                        t = m_q.pop_front();
                        if (int'(seqv[p*W +: W]) != t) m_eo = 1;
                        acc++;
                    end else begin
                        m_eu = 1;
                    end
                end
            end
            m_ret = (m_ret + acc > SMAX) ? SMAX : m_ret + acc;
            if (stat_clear) begin
                m_iss = 0; m_ret = 0; m_max = 0; m_eo = 0; m_eu = 0;
            end else if (m_q.size() > m_max) begin
                m_max = m_q.size();
            end
        end
    end

    always @(negedge clk) begin
        check("grant", int'(tx_grant), int'(rst_n && tx_req && enable && (m_q.size() < LIMIT)));
        check("seq_num", int'(tx_seq_num), m_head);
        check("inflight", int'(inflight_count), m_q.size());
        check("issued", int'(stat_issued), m_iss);
        check("returned", int'(stat_returned), m_ret);
        check("max_inflight", int'(stat_max_inflight), m_max);
        check("err_order", int'(err_order), int'(m_eo));
        check("err_underflow", int'(err_underflow), int'(m_eu));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; tx_req = 1'b0; vld = '0; stat_clear = 1'b0; enable = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic ret1(input int tag);
        vld = 2'b01;
        seqv[W-1:0] = W'(tag);
        tick();
        vld = '0;
    endtask

    initial begin
        // Reset: grant held low even with a live request.
        enable = 1'b1; tx_req = 1'b1;
        tick(); tick();
        check("lit_rst_grant", int'(tx_grant), 0);
        check("lit_rst_seq", int'(tx_seq_num), 0);
        rst_n = 1'b1;

        // Fill to the limit: 16 grants, tags 0..15.
        repeat (20) tick();
        check("lit_full_grant", int'(tx_grant), 0);
        check("lit_full_inflight", int'(inflight_count), 16);
        check("lit_full_seq", int'(tx_seq_num), 16);
        check("lit_full_max", int'(stat_max_inflight), 16);

        // Two returns on both ports in one cycle free two slots.
        vld = 2'b11; seqv = {6'd1, 6'd0};
        tick();
        vld = '0;
        check("lit_ret2_inflight", int'(inflight_count), 14);
        check("lit_ret2_grant", int'(tx_grant), 1);
        check("lit_ret2_seq", int'(tx_seq_num), 16);
        tx_req = 1'b0;

        // 70 TLPs with steady in-order returns: tag wraps past 63.
        do_reset();
        for (int i = 0; i < 72; i++) begin
            tx_req = (i < 70);
            if (i >= 1 && i <= 70) begin
                vld = 2'b01; seqv[W-1:0] = W'((i - 1) % 64);
            end else begin
                vld = '0;
            end
            tick();
        end
        vld = '0;
        check("lit_wrap_issued", int'(stat_issued), 70);
        check("lit_wrap_returned", int'(stat_returned), 70);
        check("lit_wrap_seq", int'(tx_seq_num), 6);
        check("lit_wrap_err", int'(err_order), 0);
        check("lit_wrap_inflight", int'(inflight_count), 0);

        // Order error: tail=3, tag 5 returned.
        do_reset();
        tx_req = 1'b1;
        repeat (6) tick();
        tx_req = 1'b0;
        ret1(0); ret1(1); ret1(2);
        ret1(5);
        check("lit_ord_err", int'(err_order), 1);
        check("lit_ord_inflight", int'(inflight_count), 2);
        tick();
        check("lit_ord_sticky", int'(err_order), 1);
        stat_clear = 1'b1;
        tick();
        stat_clear = 1'b0;
        check("lit_clr_err", int'(err_order), 0);
        check("lit_clr_inflight", int'(inflight_count), 2);
        check("lit_clr_issued", int'(stat_issued), 0);
        ret1(4);
        check("lit_resync_err", int'(err_order), 0);
        check("lit_resync_inflight", int'(inflight_count), 1);
        check("lit_resync_returned", int'(stat_returned), 1);

        // Underflow: one in flight, both ports valid.
        vld = 2'b11; seqv = {6'd6, 6'd5};
        tick();
        vld = '0;
        check("lit_uf_err", int'(err_underflow), 1);
        check("lit_uf_inflight", int'(inflight_count), 0);
        check("lit_uf_returned", int'(stat_returned), 2);
        check("lit_uf_order", int'(err_order), 0);

        // Return of the tag granted in the same cycle is not an underflow.
        stat_clear = 1'b1;
        tick();
        stat_clear = 1'b0;
        tx_req = 1'b1; vld = 2'b01; seqv[W-1:0] = 6'd6;
        tick();
        tx_req = 1'b0; vld = '0;
        check("lit_same_uf", int'(err_underflow), 0);
        check("lit_same_inflight", int'(inflight_count), 0);
        check("lit_same_issued", int'(stat_issued), 1);
        check("lit_same_returned", int'(stat_returned), 1);

        // enable=0 blocks grants.
        enable = 1'b0; tx_req = 1'b1;
        tick();
        check("lit_dis_grant", int'(tx_grant), 0);
        check("lit_dis_seq", int'(tx_seq_num), 7);
        enable = 1'b1;
        #1;
        check("lit_en_grant", int'(tx_grant), 1);
        tx_req = 1'b0;

        // Statistics saturate at all-ones.
        do_reset();
        for (int i = 0; i < 301; i++) begin
            tx_req = (i < 300);
            if (i >= 1) begin
                vld = 2'b01; seqv[W-1:0] = W'((i - 1) % 64);
            end else begin
                vld = '0;
            end
            tick();
        end
        vld = '0;
        check("lit_sat_issued", int'(stat_issued), 255);
        check("lit_sat_returned", int'(stat_returned), 255);

        // Async reset mid-burst.
        do_reset();
        tx_req = 1'b1;
        repeat (9) tick();
        tx_req = 1'b0;
        check("lit_pre_inflight", int'(inflight_count), 9);
        tx_req = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("lit_ar_grant", int'(tx_grant), 0);
        check("lit_ar_inflight", int'(inflight_count), 0);
        check("lit_ar_seq", int'(tx_seq_num), 0);
        check("lit_ar_issued", int'(stat_issued), 0);
        check("lit_ar_max", int'(stat_max_inflight), 0);
        tick();
        rst_n = 1'b1;
        #1;
        check("lit_post_grant", int'(tx_grant), 1);
        check("lit_post_seq", int'(tx_seq_num), 0);
        tick();
        tx_req = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
